output_layer_mac: RTL and testbench

//  Output-layer neuron engine. Sequences the hidden-neuron index and reads 10 sign-magnitude

---
 rtl/output_layer_mac_pkg.sv | 22 ++
 rtl/output_layer_mac_sm_mult.sv | 21 ++
 rtl/output_layer_mac.sv | 132 +++++++++++++
 tb/tb_output_layer_mac.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_layer_mac_pkg.sv
// Shared sizing constants and FSM state encodings for the output-layer MAC engine.
package output_layer_mac_pkg;

  localparam int unsigned N_IN_DEF  = 20;
  localparam int unsigned N_OUT     = 10;
  localparam int unsigned ACT_W_DEF = 8;
  localparam int unsigned WEIGHT_W  = 8;
  localparam int unsigned MAG_W     = WEIGHT_W - 1;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned CLASS_W   = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MAC    = 2'd1;
  localparam logic [1:0] ST_ARGMAX = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Signed product width: magnitude bits + activation bits + sign.
  function automatic int unsigned prod_width(input int unsigned act_w);
    return MAG_W + act_w + 1;
  endfunction

endpackage

// File: rtl/output_layer_mac_sm_mult.sv
// Sign-magnitude weight times unsigned activation, producing a two's-complement product.
module sm_mult
  import output_layer_mac_pkg::*;
#(
  parameter  int unsigned ACT_W  = ACT_W_DEF,
  localparam int unsigned PROD_W = prod_width(ACT_W)
) (
  input  logic [WEIGHT_W-1:0]     weight,
  input  logic [ACT_W-1:0]        act,
  output logic signed [PROD_W-1:0] prod_c
);

  logic [PROD_W-1:0] mag_prod;

  // 0x80 has zero magnitude, so negative zero naturally yields 0.
  always_comb begin
    mag_prod = PROD_W'(weight[MAG_W-1:0]) * PROD_W'(act);
    prod_c   = weight[WEIGHT_W-1] ? -$signed(mag_prod) : $signed(mag_prod);
  end

endmodule

// File: rtl/output_layer_mac.sv
// Output-layer neuron engine: 10 parallel MACs over the hidden layer, then a sequential argmax.
module output_layer_mac
  import output_layer_mac_pkg::*;
#(
  parameter  int unsigned N_IN   = N_IN_DEF,
  parameter  int unsigned ACT_W  = ACT_W_DEF,
  parameter  int unsigned ACC_W  = ACC_W_DEF,
  localparam int unsigned IDX_W  = $clog2(N_IN),
  localparam int unsigned PROD_W = prod_width(ACT_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [31:0]            weight_sel,
  input  logic [WEIGHT_W-1:0]    w0,
  input  logic [WEIGHT_W-1:0]    w1,
  input  logic [WEIGHT_W-1:0]    w2,
  input  logic [WEIGHT_W-1:0]    w3,
  input  logic [WEIGHT_W-1:0]    w4,
  input  logic [WEIGHT_W-1:0]    w5,
  input  logic [WEIGHT_W-1:0]    w6,
  input  logic [WEIGHT_W-1:0]    w7,
  input  logic [WEIGHT_W-1:0]    w8,
  input  logic [WEIGHT_W-1:0]    w9,
  output logic [IDX_W-1:0]       hidden_sel,
  input  logic [ACT_W-1:0]       hidden_act,
  output logic                   busy,
  output logic                   done,
  output logic [N_OUT*ACC_W-1:0] acc_flat,
  output logic [CLASS_W-1:0]     class_idx,
  output logic [ACC_W-1:0]       class_val
);

  logic [1:0]               state;
  logic [1:0]               state_next;
  logic [IDX_W-1:0]         idx;
  logic [CLASS_W-1:0]       j;
  logic [WEIGHT_W-1:0]      w [N_OUT];
  logic signed [PROD_W-1:0] prod [N_OUT];
  logic signed [ACC_W-1:0]  acc [N_OUT];
  logic signed [ACC_W-1:0]  best_val;
  logic [CLASS_W-1:0]       best_idx;
  logic                     idx_last;
  logic                     j_last;

  always_comb begin
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4;
    w[5] = w5; w[6] = w6; w[7] = w7; w[8] = w8; w[9] = w9;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_mult
    sm_mult #(.ACT_W(ACT_W)) u_mult (
      .weight (w[k]),
      .act    (hidden_act),
      .prod_c (prod[k])
    );
  end

  assign idx_last = (idx == IDX_W'(N_IN - 1));
  assign j_last   = (j == CLASS_W'(N_OUT - 1));

  // Memories are asynchronous-read, so the select must be valid in the same cycle as idx.
  assign hidden_sel = (state == ST_MAC) ? idx : '0;
  assign weight_sel = (state == ST_MAC) ? 32'(idx) : 32'd0;

  always_comb begin
    for (int k = 0; k < N_OUT; k++) acc_flat[k*ACC_W +: ACC_W] = acc[k];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start)    state_next = ST_MAC;
      ST_MAC:    if (idx_last) state_next = ST_ARGMAX;
      ST_ARGMAX: if (j_last)   state_next = ST_DONE;
      ST_DONE:                 state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      j         <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      class_idx <= '0;
      class_val <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else begin
      busy <= (state_next == ST_MAC) || (state_next == ST_ARGMAX);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= '0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
          end
        end
        ST_MAC: begin
          for (int k = 0; k < N_OUT; k++) acc[k] <= acc[k] + ACC_W'(prod[k]);
          idx <= idx_last ? '0 : idx + IDX_W'(1);
          if (idx_last) j <= '0;
        end
        ST_ARGMAX: begin
          // Strict compare keeps the lowest index on ties.
          if (j == '0) begin
            best_val <= acc[0];
            best_idx <= '0;
          end else if (acc[j] > best_val) begin
            best_val <= acc[j];
            best_idx <= j;
          end
          j <= j_last ? '0 : j + CLASS_W'(1);
        end
        ST_DONE: begin
          class_idx <= best_idx;
          class_val <= best_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_mac.sv
// Scoreboard bench for output_layer_mac: directed and model-based inferences.
module tb_output_layer_mac;

  localparam int unsigned NI = 20;
  localparam int unsigned NO = 10;
  localparam int unsigned AW = 24;

  typedef struct packed {
    logic [NO*AW-1:0] acc;
    logic [3:0]       cidx;
    logic [AW-1:0]    cval;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   weight_sel;
  logic [4:0]    hidden_sel;
  logic [7:0]    hidden_act;
  logic          busy;
  logic          done;
  logic [NO*AW-1:0] acc_flat;
  logic [3:0]    class_idx;
  logic [AW-1:0] class_val;

  logic [7:0] wmem [NI][NO];
  logic [7:0] amem [NI];
  logic [7:0] wv [NO];

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q[$];
  exp_t mon_e;
  exp_t e;
  int   lat;
  int   dn;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NO; k++) wv[k] = wmem[hidden_sel][k];
    hidden_act = amem[hidden_sel];
  end

  output_layer_mac dut (
    .clk(clk), .rst(rst), .start(start), .weight_sel(weight_sel),
    .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]), .w4(wv[4]),
    .w5(wv[5]), .w6(wv[6]), .w7(wv[7]), .w8(wv[8]), .w9(wv[9]),
    .hidden_sel(hidden_sel), .hidden_act(hidden_act),
    .busy(busy), .done(done), .acc_flat(acc_flat),
    .class_idx(class_idx), .class_val(class_val)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int sm2s(input logic [7:0] wt);
    return wt[7] ? -int'(wt[6:0]) : int'(wt[6:0]);
  endfunction

  function automatic exp_t uniform(input int v, input int ci, input int cv);
    exp_t r;
    for (int k = 0; k < NO; k++) r.acc[k*AW +: AW] = AW'(v);
    r.cidx = 4'(ci);
    r.cval = AW'(cv);
    return r;
  endfunction

  function automatic exp_t model();
    exp_t r;
    int s [NO];
    int best;
    int bi;
    for (int k = 0; k < NO; k++) s[k] = 0;
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < NO; k++) s[k] += sm2s(wmem[i][k]) * int'(amem[i]);
    best = s[0];
    bi   = 0;
    for (int k = 1; k < NO; k++) if (s[k] > best) begin best = s[k]; bi = k; end
    for (int k = 0; k < NO; k++) r.acc[k*AW +: AW] = AW'(s[k]);
    r.cidx = 4'(bi);
    r.cval = AW'(best);
    return r;
  endfunction

  task automatic fill(input logic [7:0] wt, input logic [7:0] a);
    for (int i = 0; i < NI; i++) begin
      amem[i] = a;
      for (int k = 0; k < NO; k++) wmem[i][k] = wt;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; -1 if the budget expires.
  task automatic wait_done(input bit chk_sel, output int l);
    l = -1;
    if (chk_sel) check("weight_sel_0", 64'(weight_sel), 64'd0);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (chk_sel) begin
        check($sformatf("weight_sel_%0d", n), 64'(weight_sel), 64'((n < 20) ? n : 0));
        check($sformatf("hidden_sel_%0d", n), 64'(hidden_sel), 64'(weight_sel));
      end
      if (done) begin
        l = n;
        return;
      end
    end
  endtask

  task automatic run(input exp_t ex, input bit chk_sel, input string name);
    q.push_back(ex);
    start_pulse();
    wait_done(chk_sel, lat);
    check({name, "_latency"}, 64'(lat), 64'd31);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1, expected no pending inference");
      end else begin
        mon_e = q.pop_front();
        for (int k = 0; k < NO; k++)
          check($sformatf("acc%0d", k), 64'(acc_flat[k*AW +: AW]), 64'(mon_e.acc[k*AW +: AW]));
        check("class_idx", 64'(class_idx), 64'(mon_e.cidx));
        check("class_val", 64'(class_val), 64'(mon_e.cval));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_acc", 64'(|acc_flat), 64'd0);
    check("rst_class_idx", 64'(class_idx), 64'd0);
    check("rst_class_val", 64'(class_val), 64'd0);
    check("rst_weight_sel", 64'(weight_sel), 64'd0);

    // All +1 weights, act 1: ties resolve to class 0.
    fill(8'h01, 8'd1);
    run(uniform(20, 0, 20), 1'b0, "t1");

    // Only row 3 at max magnitude, act 255: 20*127*255 = 647700.
    fill(8'h00, 8'hFF);
    for (int i = 0; i < NI; i++) wmem[i][3] = 8'h7F;
    e = uniform(0, 3, 647700);
    e.acc[3*AW +: AW] = AW'(647700);
    run(e, 1'b0, "t2");

    // All -1 weights, act 10: every sum -200.
    fill(8'h81, 8'd10);
    run(uniform(-200, 0, -200), 1'b0, "t3");

    // Negative zero on neuron 4 contributes nothing, so it wins with 0.
    fill(8'h81, 8'd10);
    for (int i = 0; i < NI; i++) wmem[i][4] = 8'h80;
    e = uniform(-200, 4, 0);
    e.acc[4*AW +: AW] = '0;
    run(e, 1'b0, "t3b");

    // Reset mid-MAC: aborts cleanly without a done pulse.
    fill(8'h01, 8'd1);
    start_pulse();
    repeat (7) @(posedge clk);
    #1;
    check("abort_idx7", 64'(weight_sel), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_acc", 64'(|acc_flat), 64'd0);
    check("abort_class_idx", 64'(class_idx), 64'd0);
    check("abort_class_val", 64'(class_val), 64'd0);
    check("abort_weight_sel", 64'(weight_sel), 64'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1 dn += int'(done);
    end
    check("abort_no_done", 64'(dn), 64'd0);
    run(uniform(20, 0, 20), 1'b0, "t4_restart");

    // start held high: one inference per accept, re-accept right after done.
    fill(8'h01, 8'd2);
    q.push_back(uniform(40, 0, 40));
    q.push_back(uniform(40, 0, 40));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(1'b0, lat);
    check("t5_latency_a", 64'(lat), 64'd31);
    @(posedge clk);
    #1;
    check("t5_reaccept_busy", 64'(busy), 64'd1);
    check("t5_reaccept_acc_clear", 64'(|acc_flat), 64'd0);
    start = 1'b0;
    wait_done(1'b0, lat);
    check("t5_latency_b", 64'(lat), 64'd31);

    // Random weights/activations against the reference model, with select stepping checked.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NI; i++) begin
        amem[i] = 8'($urandom);
        for (int k = 0; k < NO; k++) wmem[i][k] = 8'($urandom);
      end
      run(model(), 1'b1, $sformatf("t6_%0d", r));
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
